// File: rtl/ps2_key_fifo.sv
// PS/2 Set-2 scan-code decoder with Shift/Caps tracking, ASCII mapping and a FWFT output FIFO.
// Define PS2KEY_TYPEMATIC_FILTER_EN to suppress typematic repeats of the last pushed make code.
module ps2_key_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          frame_err,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          shift_st,
  output logic          caps_st
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } state_t;

  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  state_t        state_q, state_d;
  logic          is_make, is_break;
  logic          lshift_q, rshift_q, caps_q;
  logic          map_hit, map_letter;
  logic [7:0]    map_char, char_out;
  logic          repeat_block;
  logic          push_req, do_push, do_pop, full;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Prefix decoder: classifies each good byte as a make, a break, or a prefix to absorb.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (byte_valid) begin
      if (frame_err) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_in == 8'hE0)      state_d = S_E0;
            else if (byte_in == 8'hF0) state_d = S_F0;
            else                       is_make = 1'b1;
          end
          S_E0: begin
            if (byte_in == 8'hF0) state_d = S_E0F0;
            else                  state_d = S_IDLE;
          end
          S_F0: begin
            is_break = 1'b1;
            state_d  = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
    end else begin
      if (is_make) begin
        if (byte_in == 8'h12) lshift_q <= 1'b1;
        if (byte_in == 8'h59) rshift_q <= 1'b1;
        if (byte_in == 8'h58) caps_q   <= ~caps_q;
      end
      if (is_break) begin
        if (byte_in == 8'h12) lshift_q <= 1'b0;
        if (byte_in == 8'h59) rshift_q <= 1'b0;
      end
    end
  end

  assign shift_st = lshift_q | rshift_q;
  assign caps_st  = caps_q;

  // Letters are looked up in lowercase; case folding uses the modifier state before this byte.
  always_comb begin
    map_hit    = 1'b1;
    map_letter = 1'b1;
    map_char   = 8'h00;
    case (byte_in)
      8'h1C: map_char = 8'h61;
      8'h32: map_char = 8'h62;
      8'h21: map_char = 8'h63;
      8'h23: map_char = 8'h64;
      8'h24: map_char = 8'h65;
      8'h2B: map_char = 8'h66;
      8'h34: map_char = 8'h67;
      8'h33: map_char = 8'h68;
      8'h43: map_char = 8'h69;
      8'h3B: map_char = 8'h6A;
      8'h42: map_char = 8'h6B;
      8'h4B: map_char = 8'h6C;
      8'h3A: map_char = 8'h6D;
      8'h31: map_char = 8'h6E;
      8'h44: map_char = 8'h6F;
      8'h4D: map_char = 8'h70;
      8'h15: map_char = 8'h71;
      8'h2D: map_char = 8'h72;
      8'h1B: map_char = 8'h73;
      8'h2C: map_char = 8'h74;
      8'h3C: map_char = 8'h75;
      8'h2A: map_char = 8'h76;
      8'h1D: map_char = 8'h77;
      8'h22: map_char = 8'h78;
      8'h35: map_char = 8'h79;
      8'h1A: map_char = 8'h7A;
      default: begin
        map_letter = 1'b0;
        case (byte_in)
          8'h45: map_char = 8'h30;
          8'h16: map_char = 8'h31;
          8'h1E: map_char = 8'h32;
          8'h26: map_char = 8'h33;
          8'h25: map_char = 8'h34;
          8'h2E: map_char = 8'h35;
          8'h36: map_char = 8'h36;
          8'h3D: map_char = 8'h37;
          8'h3E: map_char = 8'h38;
          8'h46: map_char = 8'h39;
          8'h29: map_char = 8'h20;
          8'h5A: map_char = 8'h0D;
          8'h66: map_char = 8'h08;
          default: map_hit = 1'b0;
        endcase
      end
    endcase
    char_out = (map_letter && (shift_st ^ caps_st)) ? (map_char - 8'h20) : map_char;
  end

`ifdef PS2KEY_TYPEMATIC_FILTER_EN
  logic [7:0] last_code_q;
  logic       last_valid_q;

  assign repeat_block = last_valid_q && (last_code_q == byte_in);

  // Any other make (modifiers included) or a break of the remembered code re-arms the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_code_q  <= 8'h00;
      last_valid_q <= 1'b0;
    end else if (is_make) begin
      last_code_q  <= byte_in;
      last_valid_q <= map_hit;
    end else if (is_break && (byte_in == last_code_q)) begin
      last_valid_q <= 1'b0;
    end
  end
`else
  assign repeat_block = 1'b0;
`endif

  assign push_req  = is_make & map_hit & ~repeat_block;
  assign full      = (count_q == FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign do_pop    = out_valid & out_ready;
  assign do_push   = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= char_out;
  end

  // Pointers wrap naturally at DEPTH; occupancy is tracked separately to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                 overflow_q <= 1'b0;
    else if (push_req && full && !do_pop)    overflow_q <= 1'b1;
    else if (ovf_clr)                        overflow_q <= 1'b0;
  end

  assign out_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Downstream stage of the PS/2 frame receiver. Consumes one scan-code byte per received frame.
- Decodes Set-2 make, break (F0) and extended (E0) prefixes. Tracks Shift and Caps Lock, maps make codes to ASCII, and queues the characters in a first-word-fall-through FIFO.
- Consumers (display/text logic) drain the FIFO with a valid/ready handshake, so keystrokes are not lost between reads.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, ≥2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- byte_in  input  8  scan-code byte from the frame receiver.
- byte_valid  input  1  one-cycle strobe; byte_in is valid in this cycle.
- frame_err  input  1  qualifies byte_valid; 1 = parity/stop error on this byte.
- out_data  output  8  ASCII at the FIFO head; valid only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head entry when out_valid & out_ready.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a character was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow (one cycle).
- shift_st  output  1  1 while any Shift key is held.
- caps_st  output  1  Caps Lock toggle state.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, count=0, out_valid=0, overflow=0, shift_st=0, caps_st=0, prefix FSM in IDLE, both shift flags cleared. rst overrides every other input, including a byte_valid in the same cycle.
- Bytes are considered only when byte_valid=1. If frame_err=1 on that byte: discard it, FSM returns to IDLE, no push.
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - IDLE: E0→E0; F0→F0; any other byte is a make code, process it, stay in IDLE.
  - E0: F0→E0F0; any other byte is an extended make, discard it, →IDLE.
  - F0: byte is a break code, process it, →IDLE.
  - E0F0: byte is an extended break, discard it, →IDLE.
  - A byte E0 or F0 arriving in F0/E0F0 is treated as a code, not a prefix.
- Modifier processing:
  - make 12 sets lshift; break 12 clears it.
  - make 59 sets rshift; break 59 clears it.
  - shift_st = lshift | rshift.
  - make 58 toggles caps_st on every make, including typematic repeats. Break 58 has no effect.
  - Modifier codes are never pushed.
- Character mapping (make codes only; breaks never push):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Letter case: uppercase (41..5A) when shift_st XOR caps_st, else lowercase (61..7A). The shift_st/caps_st values used are those held before the current byte.
  - Digits (shift ignored): 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29 → 20 (space), 5A → 0D (enter), 66 → 08 (backspace).
  - Unmapped codes: no push, no state change.
- Typematic repeats of a mapped make push once per received make byte.
- FIFO push:
  - Push happens on the same edge that samples the byte. out_valid rises the next cycle if the FIFO was empty, so latency is 1 clk from byte_valid to out_valid.
  - out_data is first-word-fall-through: head entry, registered storage.
- FIFO pop: on out_valid & out_ready; the head advances on that edge.
- Simultaneous push and pop: both happen and count is unchanged. When full, a same-cycle pop frees space, so the push is accepted and overflow is not set.
- Full with no pop: the push is dropped and overflow is set. Stored data and pointers are unchanged.
- Empty: out_ready is ignored and count stays 0.
- Pointers are AW bits and wrap modulo DEPTH. count = pushes − pops.
- overflow: set has priority over ovf_clr in the same cycle.

Optional Feature:
- Macro: PS2KEY_TYPEMATIC_FILTER_EN.
- Defined:
  - The block remembers the last pushed make code.
  - A repeated make of the same code, with no intervening break of that code, is not pushed.
  - A break of that code, a different make code, or reset clears the memory.
  - Modifier codes are unaffected; Caps Lock still toggles on every make.
- Not defined: every mapped make is pushed, as specified above.

Test Plan:
- Byte 1C (frame_err=0), FIFO empty → next cycle out_valid=1, out_data=61, count=1. Then out_ready=1 for one cycle → out_valid=0, count=0.
- Bytes 12, 1C, F0, 12, 1C → FIFO holds 41, 61; shift_st ends at 0. Then 58, 1C → caps_st=1, FIFO gains 41.
- Bytes E0, 75, E0, F0, 75, F0, 1C → no push, FSM back in IDLE. Byte 1C with frame_err=1 → no push.
- With out_ready=0, push DEPTH+1 copies of 16 → count=16, overflow=1, head=31. Then a push and pop in the same cycle → count stays 16, overflow unchanged. Then ovf_clr → overflow=0.
- Push 20 characters while popping every other cycle → output sequence matches input order across the pointer wrap.
- rst asserted mid-sequence (after F0 sent, FIFO count=3) → count=0, out_valid=0, FSM IDLE. The next byte 1C is treated as a make and pushes 61. With PS2KEY_TYPEMATIC_FILTER_EN: 1C, 1C, 1C → one push; then F0, 1C, 1C → second push.
